// File: rtl/gpi_periph.sv
// Memory-mapped general-purpose input block. Pins pass through a two-flop synchronizer
// and a per-pin debounce counter. Enabled edges latch into write-1-to-clear PEND flags that drive irq.
module gpi_periph #(
    parameter logic [9:0]  BASE_ADDR       = 10'h54,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WIDTH           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       address,
    input  logic [WIDTH-1:0] data,
    input  logic             write,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] data_out,
    output logic             irq
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [9:0] ADDR_LEVEL   = BASE_ADDR;
    localparam logic [9:0] ADDR_PEND    = BASE_ADDR + 10'd4;
    localparam logic [9:0] ADDR_RISE_EN = BASE_ADDR + 10'd8;
    localparam logic [9:0] ADDR_FALL_EN = BASE_ADDR + 10'd12;

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise_set, fall_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pins;
            s2_q <= s1_q;
        end
    end

    // One independent debounce counter per pin; accept pulses for one cycle when a new level is taken.
    generate
        for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             acc;

            always_comb begin
                cnt_d = cnt_q;
                acc   = 1'b0;
                if (s2_q[gi] == level_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    acc   = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign accept[gi] = acc;
        end
    endgenerate

    // Edge direction comes from the pre-edge level; enables are the pre-edge values too.
    assign level_d  = level_q ^ accept;
    assign rise_set = accept & ~level_q & rise_en_q;
    assign fall_set = accept &  level_q & fall_en_q;

    always_comb begin
        pend_d    = pend_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (write) begin
            case (address)
                ADDR_PEND:    pend_d    = pend_q & ~data;
                ADDR_RISE_EN: rise_en_d = data;
                ADDR_FALL_EN: fall_en_d = data;
                default:      ;
            endcase
        end
        // A capture on the same edge as a clear must survive.
        pend_d = pend_d | rise_set | fall_set;
    end

    always_comb begin
        data_out_d = '0;
        case (address)
            ADDR_LEVEL:   data_out_d = level_q;
            ADDR_PEND:    data_out_d = pend_q;
            ADDR_RISE_EN: data_out_d = rise_en_q;
            ADDR_FALL_EN: data_out_d = fall_en_q;
            default:      data_out_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q    <= '0;
            pend_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            data_out_q <= '0;
        end else begin
            level_q    <= level_d;
            pend_q     <= pend_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign irq      = |pend_q;

endmodule

// File: tb/tb_gpi_periph.sv
// Directed bench for gpi_periph: a register-access vector table followed by
// hand-written debounce, edge-capture, clear-collision and reset sequences.
module tb_gpi_periph;

    localparam logic [9:0] A_LEVEL = 10'h54;
    localparam logic [9:0] A_PEND  = 10'h58;
    localparam logic [9:0] A_RISE  = 10'h5C;
    localparam logic [9:0] A_FALL  = 10'h60;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] address;
    logic [7:0] data;
    logic       write;
    logic [7:0] pins;
    logic [7:0] data_out;
    logic       irq;

    int tests_run    = 0;
    int tests_failed = 0;

    gpi_periph #(
        .BASE_ADDR      (10'h54),
        .DEBOUNCE_CYCLES(4),
        .WIDTH          (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .data    (data),
        .write   (write),
        .pins    (pins),
        .data_out(data_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_do;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] %s: got %h ok", name, act);
        end
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, {7'b0, irq}, {7'b0, exp});
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [7:0] d);
        address = a;
        data    = d;
        write   = 1'b1;
        tick();
        write   = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [9:0] a, input logic [7:0] exp);
        address = a;
        write   = 1'b0;
        tick();
        check(name, data_out, exp);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vecs[0]  = '{1'b1, A_RISE,  8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, A_RISE,  8'h00, 8'hA5, 1'b0};
        vecs[2]  = '{1'b1, A_FALL,  8'h3C, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, A_FALL,  8'h00, 8'h3C, 1'b0};
        vecs[4]  = '{1'b1, A_LEVEL, 8'hFF, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, A_LEVEL, 8'h00, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 10'h3FC, 8'h55, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 10'h3FC, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, A_PEND,  8'h00, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 10'h50,  8'h00, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 10'h15C, 8'hFF, 8'h00, 1'b0};
        vecs[11] = '{1'b0, A_RISE,  8'h00, 8'hA5, 1'b0};
        vecs[12] = '{1'b0, A_FALL,  8'h00, 8'h3C, 1'b0};

        rst     = 1'b1;
        address = A_LEVEL;
        data    = 8'h00;
        write   = 1'b0;
        pins    = 8'h00;
        wait_cycles(3);
        rst = 1'b0;

        // Reset state
        bus_read("reset_level", A_LEVEL, 8'h00);
        check_irq("reset_irq", 1'b0);

        // Register map vectors; data_out shows contents before each edge
        for (int i = 0; i < 13; i++) begin
            address = vecs[i].addr;
            data    = vecs[i].wdata;
            write   = vecs[i].wr;
            tick();
            write   = 1'b0;
            check($sformatf("vec%0d_do", i), data_out, vecs[i].exp_do);
            check_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
        end
        bus_write(A_RISE, 8'h00);
        bus_write(A_FALL, 8'h00);

        // Latency: pins change before edge k; LEVEL after k+5, data_out after k+6
        address = A_LEVEL;
        tick();
        pins = 8'h81;
        for (int j = 0; j <= 6; j++) begin
            tick();
            check($sformatf("lat_k%0d", j), data_out, (j == 6) ? 8'h81 : 8'h00);
        end

        // Edge capture: rise on bit 0, fall on bit 7
        pins = 8'h00;
        wait_cycles(8);
        bus_read("cap_idle_pend", A_PEND, 8'h00);
        bus_write(A_RISE, 8'h01);
        bus_write(A_FALL, 8'h80);
        pins = 8'h81;
        wait_cycles(8);
        bus_read("cap_rise_pend", A_PEND, 8'h01);
        check_irq("cap_rise_irq", 1'b1);
        pins = 8'h01;
        wait_cycles(8);
        bus_read("cap_fall_pend", A_PEND, 8'h81);

        // Write-1-to-clear and read-only LEVEL
        bus_write(A_PEND, 8'h80);
        bus_read("w1c_a_pend", A_PEND, 8'h01);
        check_irq("w1c_a_irq", 1'b1);
        bus_write(A_PEND, 8'h01);
        bus_read("w1c_b_pend", A_PEND, 8'h00);
        check_irq("w1c_b_irq", 1'b0);
        bus_write(A_LEVEL, 8'hFF);
        bus_read("ro_level", A_LEVEL, 8'h01);

        // Glitch of 3 samples on pin 3 is rejected, 4 samples accepted
        bus_write(A_RISE, 8'hFF);
        pins = 8'h09;
        wait_cycles(3);
        pins = 8'h01;
        address = A_PEND;
        for (int j = 0; j < 8; j++) begin
            tick();
            check_irq($sformatf("glitch_irq%0d", j), 1'b0);
        end
        bus_read("glitch_level", A_LEVEL, 8'h01);
        bus_read("glitch_pend", A_PEND, 8'h00);
        pins = 8'h09;
        wait_cycles(4);
        pins = 8'h01;
        wait_cycles(8);
        bus_read("pulse_pend", A_PEND, 8'h08);
        check_irq("pulse_irq", 1'b1);
        bus_write(A_PEND, 8'h08);
        bus_read("pulse_clr", A_PEND, 8'h00);

        // Clear of bit 0 on the same edge as its rising accept: set wins
        pins = 8'h00;
        wait_cycles(8);
        bus_read("coll_pre", A_PEND, 8'h00);
        pins = 8'h01;
        wait_cycles(5);
        bus_write(A_PEND, 8'h01);
        bus_read("coll_pend", A_PEND, 8'h01);
        check_irq("coll_irq", 1'b1);

        // Reset in the middle of a debounce
        address = A_PEND;
        pins = 8'h81;
        wait_cycles(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_do", data_out, 8'h00);
        check_irq("mid_rst_irq", 1'b0);
        address = A_LEVEL;
        for (int j = 1; j <= 7; j++) begin
            tick();
            check($sformatf("mid_rst_lat%0d", j), data_out, (j == 7) ? 8'h81 : 8'h00);
        end
        bus_read("mid_rst_rise", A_RISE, 8'h00);
        bus_read("mid_rst_fall", A_FALL, 8'h00);
        bus_read("mid_rst_pend", A_PEND, 8'h00);
        bus_read("unmapped_3fc", 10'h3FC, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
